chain_mixer_dose_ctrl: RTL and testbench

Sequential valve controller that sits directly upstream of the serial chain mixer. It drives the carrier inlet (j0) and the per-stage reagent inlets (k0..kN-1) of an N-stage mixer chain. Each run fills the chain with carrier, then doses each stage's reagent in order, with a timed mix dwell after each dose. One run is launched by a start handshake and reports completion with a done pulse.

---
 rtl/chain_mixer_pkg.sv | 15 +
 rtl/chain_mixer_dose_ctrl_if.sv | 32 +++
 rtl/dose_timer.sv | 28 ++
 rtl/chain_mixer_dose_ctrl.sv | 153 +++++++++++++++
 tb/tb_chain_mixer_dose_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/chain_mixer_pkg.sv
// Shared types and default sizing for the serial chain mixer blocks and their benches.
package chain_mixer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DOSE,
        MIX,
        DONE
    } dose_state_e;

    localparam int unsigned DEFAULT_N_STAGES = 32;
    localparam int unsigned DEFAULT_CNT_W    = 16;

endpackage

// File: rtl/chain_mixer_dose_ctrl_if.sv
// Run handshake and valve bus of the chain mixer dose controller.
interface chain_mixer_dose_ctrl_if
    import chain_mixer_pkg::*;
#(
    parameter int unsigned N_STAGES = DEFAULT_N_STAGES,
    parameter int unsigned CNT_W    = DEFAULT_CNT_W
) ();

    localparam int unsigned STG_W = $clog2(N_STAGES);

    logic                start;
    logic                abort;
    logic [CNT_W-1:0]    dose_cycles;
    logic [CNT_W-1:0]    mix_cycles;
    logic                carrier_valve;
    logic [N_STAGES-1:0] reagent_valve;
    logic [STG_W-1:0]    stage;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output start, abort, dose_cycles, mix_cycles,
        input  carrier_valve, reagent_valve, stage, busy, done, err
    );

    modport slave (
        input  start, abort, dose_cycles, mix_cycles,
        output carrier_valve, reagent_valve, stage, busy, done, err
    );

endinterface

// File: rtl/dose_timer.sv
// Loadable down-counter; holds at zero and flags it so the FSM can leave a timed state.
module dose_timer
    import chain_mixer_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/chain_mixer_dose_ctrl.sv
// Sequences carrier fill, then per-stage reagent dose and mix dwell, for an N-stage mixer chain.
module chain_mixer_dose_ctrl
    import chain_mixer_pkg::*;
#(
    parameter int unsigned N_STAGES = DEFAULT_N_STAGES,
    parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    chain_mixer_dose_ctrl_if.slave  bus
);

    localparam int unsigned STG_W = $clog2(N_STAGES);
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(N_STAGES - 1);

    dose_state_e         state_q, state_d;
    logic [STG_W-1:0]    stage_q, stage_d;
    logic [CNT_W-1:0]    dose_q, dose_d;
    logic [CNT_W-1:0]    mix_q, mix_d;
    logic                load;
    logic [CNT_W-1:0]    load_val;
    logic                cnt_zero;
    logic                advance;

    logic                carrier_q, carrier_d;
    logic [N_STAGES-1:0] reagent_q, reagent_d;
    logic [STG_W-1:0]    stage_out_q, stage_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    dose_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            dose_q      <= '0;
            mix_q       <= '0;
            carrier_q   <= 1'b0;
            reagent_q   <= '0;
            stage_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            dose_q      <= dose_d;
            mix_q       <= mix_d;
            carrier_q   <= carrier_d;
            reagent_q   <= reagent_d;
            stage_out_q <= stage_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        dose_d   = dose_q;
        mix_d    = mix_q;
        load     = 1'b0;
        load_val = '0;
        advance  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.dose_cycles != '0) begin
                        state_d  = FILL;
                        stage_d  = '0;
                        dose_d   = bus.dose_cycles;
                        mix_d    = bus.mix_cycles;
                        load     = 1'b1;
                        load_val = bus.dose_cycles - CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (cnt_zero) begin
                    state_d  = DOSE;
                    load     = 1'b1;
                    load_val = dose_q - CNT_W'(1);
                end
            end
            DOSE: begin
                if (cnt_zero) begin
                    if (mix_q != '0) begin
                        state_d  = MIX;
                        load     = 1'b1;
                        load_val = mix_q - CNT_W'(1);
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            MIX:     advance = cnt_zero;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (stage_q == LAST_STAGE) begin
                state_d = DONE;
            end else begin
                state_d  = DOSE;
                stage_d  = stage_q + STG_W'(1);
                load     = 1'b1;
                load_val = dose_q - CNT_W'(1);
            end
        end

        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    // Outputs decode the next state so they can be registered without a cycle of lag.
    always_comb begin
        carrier_d   = (state_d == FILL);
        reagent_d   = '0;
        stage_out_d = '0;
        if (state_d == DOSE) begin
            reagent_d[stage_d] = 1'b1;
        end
        if (state_d == DOSE || state_d == MIX) begin
            stage_out_d = stage_d;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.carrier_valve = carrier_q;
    assign bus.reagent_valve = reagent_q;
    assign bus.stage         = stage_out_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_chain_mixer_dose_ctrl.sv
// Directed bench for the 4-stage dose controller: vector table plus abort/reset/held-start sequences.
module tb_chain_mixer_dose_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 16;

    typedef struct {
        int d;
        int m;
        int done_cycle;
        int err_pulses;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    chain_mixer_dose_ctrl_if #(.N_STAGES(N), .CNT_W(CW)) bus ();

    chain_mixer_dose_ctrl #(
        .N_STAGES (N),
        .CNT_W    (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {carrier, reagent[3:0], stage[1:0], busy, done, err}
    logic [9:0] obs;
    assign obs = {bus.carrier_valve, bus.reagent_valve, bus.stage, bus.busy, bus.done, bus.err};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outputs for cycle c of a run (c=1 is the first cycle after the start edge).
    function automatic logic [9:0] exp_out(input int d, input int m, input int c);
        logic       carrier = 1'b0;
        logic [3:0] reagent = '0;
        logic [1:0] stg     = '0;
        logic       busy    = 1'b0;
        logic       dn      = 1'b0;
        logic       err     = 1'b0;
        int         len     = d + 4 * (d + m) + 1;
        if (d == 0) begin
            err = (c == 1);
        end else if (c >= 1 && c <= len) begin
            busy = 1'b1;
            if (c <= d) begin
                carrier = 1'b1;
            end else if (c == len) begin
                dn = 1'b1;
            end else begin
                int k = (c - d - 1) / (d + m);
                int r = (c - d - 1) % (d + m);
                stg = 2'(k);
                if (r < d) reagent[k] = 1'b1;
            end
        end
        return {carrier, reagent, stg, busy, dn, err};
    endfunction

    task automatic check_cycle(input string tag, input int d, input int m, input int c);
        check($sformatf("%s c%0d outputs", tag, c), int'(obs), int'(exp_out(d, m, c)));
        check($sformatf("%s c%0d one-valve", tag, c),
              int'($countones({bus.carrier_valve, bus.reagent_valve}) > 1), 0);
    endtask

    task automatic launch(input int d, input int m, input logic with_abort);
        bus.start       = 1'b1;
        bus.abort       = with_abort;
        bus.dose_cycles = CW'(d);
        bus.mix_cycles  = CW'(m);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic run_full(input string tag, input int d, input int m, input int exp_done,
                            input int exp_err, input logic with_abort);
        int len      = (d == 0) ? 1 : d + 4 * (d + m) + 1;
        int seen     = 0;
        int err_seen = 0;
        launch(d, m, with_abort);
        for (int c = 1; c <= len + 2; c++) begin
            check_cycle(tag, d, m, c);
            if (bus.done && seen == 0) seen = c;
            if (bus.err) err_seen++;
            @(negedge clk);
        end
        check({tag, " done cycle"}, seen, exp_done);
        check({tag, " err pulses"}, err_seen, exp_err);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{d: 3, m: 2, done_cycle: 24, err_pulses: 0};
        vecs[1] = '{d: 1, m: 0, done_cycle: 6,  err_pulses: 0};
        vecs[2] = '{d: 0, m: 5, done_cycle: 0,  err_pulses: 1};
        vecs[3] = '{d: 2, m: 1, done_cycle: 15, err_pulses: 0};
        vecs[4] = '{d: 1, m: 3, done_cycle: 18, err_pulses: 0};

        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.dose_cycles = '0;
        bus.mix_cycles  = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", int'(obs), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle outputs", int'(obs), 0);

        // Abort alone in IDLE does nothing.
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort in idle", int'(obs), 0);

        foreach (vecs[i]) begin
            run_full($sformatf("vec%0d", i), vecs[i].d, vecs[i].m, vecs[i].done_cycle,
                     vecs[i].err_pulses, 1'b0);
        end

        // Start and abort together in IDLE: start wins.
        run_full("start+abort", 1, 0, 6, 0, 1'b1);

        // Abort in stage-2 DOSE (cycles 14..16 for D=3, M=2).
        launch(3, 2, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            check_cycle("abort", 3, 2, c);
            if (c < 14) @(negedge clk);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("post-abort c%0d", c), int'(obs), 0);
            @(negedge clk);
        end
        run_full("after abort", 3, 2, 24, 0, 1'b0);

        // Start held through a run with inputs changed mid-run; re-launch right after DONE.
        bus.start       = 1'b1;
        bus.dose_cycles = CW'(3);
        bus.mix_cycles  = CW'(2);
        @(negedge clk);
        for (int c = 1; c <= 25; c++) begin
            if (c == 5) begin
                bus.dose_cycles = CW'(7);
                bus.mix_cycles  = CW'(9);
            end
            check_cycle("held", 3, 2, c);
            @(negedge clk);
        end
        bus.start = 1'b0;
        for (int c = 1; c <= 73; c++) begin
            check_cycle("held run2", 7, 9, c);
            @(negedge clk);
        end

        // Reset mid-MIX (cycle 8 for D=3, M=2) with abort also high.
        launch(3, 2, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            check_cycle("rst", 3, 2, c);
            @(negedge clk);
        end
        rst       = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        check("rst mid-mix outputs", int'(obs), 0);
        rst       = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        check("rst released idle", int'(obs), 0);
        run_full("after rst", 3, 2, 24, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
